// File: rtl/fifo_wptr_full.sv
// Write-domain side of the async FIFO: binary/Gray write pointer, two-flop read-pointer
// synchroniser, and registered full / almost_full / level / sticky overflow flags.
module fifo_wptr_full #(
  parameter int unsigned NUM_BITS     = 4,
  parameter int unsigned DEPTH        = 16,
  parameter int unsigned AFULL_THRESH = 12
) (
  input  logic                w_clk,
  input  logic                w_rst,
  input  logic                w_en,
  input  logic [NUM_BITS:0]   rd_ptr_gray,
  output logic [NUM_BITS-1:0] w_ptr_bin,
  output logic [NUM_BITS:0]   w_ptr_gray,
  output logic                full,
  output logic                almost_full,
  output logic [NUM_BITS:0]   w_level,
  output logic                overflow
);

  localparam int unsigned N = NUM_BITS;
  // An out-of-range threshold saturates at DEPTH so almost_full still asserts when full.
  localparam int unsigned AfullEff = (AFULL_THRESH > DEPTH) ? DEPTH : AFULL_THRESH;
  localparam logic [N:0]  AfullLvl = (N+1)'(AfullEff);

  logic [N:0] wbin_q, wbin_d;
  logic [N:0] wgray_q, wgray_d;
  logic [N:0] rq1_q, rq2_q;
  logic [N:0] rbin_s;
  logic [N:0] level_q, level_d;
  logic       full_q, full_d;
  logic       afull_q, afull_d;
  logic       ovf_q, ovf_d;
  logic       push;

  always_comb begin
    push    = w_en & ~full_q;
    wbin_d  = wbin_q + {{N{1'b0}}, push};
    wgray_d = (wbin_d >> 1) ^ wbin_d;
    rbin_s  = '0;
    for (int i = 0; i <= int'(N); i++) begin
      rbin_s[i] = ^(rq2_q >> i);
    end
    // Full when the write pointer is exactly one lap ahead of the synchronised read pointer.
    full_d  = (wgray_d == {~rq2_q[N:N-1], rq2_q[N-2:0]});
    level_d = wbin_d - rbin_s;
    afull_d = (level_d >= AfullLvl);
    ovf_d   = ovf_q | (w_en & full_q);
  end

  always_ff @(posedge w_clk) begin
    if (w_rst) begin
      wbin_q  <= '0;
      wgray_q <= '0;
      rq1_q   <= '0;
      rq2_q   <= '0;
      level_q <= '0;
      full_q  <= 1'b0;
      afull_q <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      wbin_q  <= wbin_d;
      wgray_q <= wgray_d;
      rq1_q   <= rd_ptr_gray;
      rq2_q   <= rq1_q;
      level_q <= level_d;
      full_q  <= full_d;
      afull_q <= afull_d;
      ovf_q   <= ovf_d;
    end
  end

  assign w_ptr_bin   = wbin_q[N-1:0];
  assign w_ptr_gray  = wgray_q;
  assign full        = full_q;
  assign almost_full = afull_q;
  assign w_level     = level_q;
  assign overflow    = ovf_q;

endmodule

// File: tb/tb_fifo_wptr_full.sv
// Randomised bench for fifo_wptr_full against a count-based occupancy model
// (unbounded write/read counts, read count seen two edges late by the write domain).
module tb_fifo_wptr_full;

  localparam int unsigned NumBits = 4;
  localparam int          Depth   = 16;
  localparam int          Thresh  = 12;

  logic               clk = 1'b0;
  logic               rst;
  logic               en;
  logic [NumBits:0]   rd_gray;
  logic [NumBits-1:0] ptr_bin;
  logic [NumBits:0]   ptr_gray;
  logic               full;
  logic               almost_full;
  logic [NumBits:0]   level;
  logic               overflow;

  fifo_wptr_full #(
    .NUM_BITS    (NumBits),
    .DEPTH       (Depth),
    .AFULL_THRESH(Thresh)
  ) dut (
    .w_clk      (clk),
    .w_rst      (rst),
    .w_en       (en),
    .rd_ptr_gray(rd_gray),
    .w_ptr_bin  (ptr_bin),
    .w_ptr_gray (ptr_gray),
    .full       (full),
    .almost_full(almost_full),
    .w_level    (level),
    .overflow   (overflow)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  // Reference state: total writes accepted, total reads issued, and the read count
  // as sampled one and two edges ago.
  int m_wcnt = 0;
  int rd_cnt = 0;
  int rd_seen1 = 0;
  int rd_seen2 = 0;
  int m_level = 0;
  bit m_full = 1'b0;
  bit m_ovf = 1'b0;
  bit last_push = 1'b0;

  function automatic logic [NumBits:0] to_gray(input int v);
    logic [NumBits:0] b;
    b = NumBits'(0) + (NumBits+1)'(v % (1 << (NumBits + 1)));
    return b ^ (b >> 1);
  endfunction

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic step(input bit we, input bit wr);
    @(negedge clk);
    en      = we;
    rst     = wr;
    rd_gray = to_gray(rd_cnt);
    @(posedge clk);
    if (wr) begin
      m_wcnt = 0; m_ovf = 0; m_full = 0; m_level = 0;
      rd_seen1 = 0; rd_seen2 = 0; last_push = 0;
    end else begin
      last_push = we && !m_full;
      if (we && m_full) m_ovf = 1;
      if (last_push) m_wcnt++;
      m_level  = m_wcnt - rd_seen2;
      rd_seen2 = rd_seen1;
      rd_seen1 = rd_cnt;
      m_full   = (m_level == Depth);
    end
    #1;
    check_eq("w_ptr_bin", 32'(ptr_bin), 32'(m_wcnt % Depth));
    check_eq("w_ptr_gray", 32'(ptr_gray), 32'(to_gray(m_wcnt)));
    check_eq("w_level", 32'(level), 32'(m_level));
    check_eq("full", 32'(full), 32'(m_full));
    check_eq("almost_full", 32'(almost_full), 32'(m_level >= Thresh));
    check_eq("overflow", 32'(overflow), 32'(m_ovf));
  endtask

  initial begin
    logic [NumBits:0] prev_gray;
    en = 0; rst = 1; rd_gray = '0;

    // Reset held two cycles with a write request pending.
    rd_cnt = 0;
    step(1'b1, 1'b1);
    step(1'b1, 1'b1);

    // Fill with the read side idle, then one write while full.
    for (int i = 0; i < Depth; i++) step(1'b1, 1'b0);
    check_eq("fill_gray", 32'(ptr_gray), 32'h18);
    step(1'b1, 1'b0);
    step(1'b0, 1'b0);
    check_eq("ovf_sticky", 32'(overflow), 32'd1);

    // Release four entries: visible on the third edge.
    rd_cnt = 4;
    for (int i = 0; i < 3; i++) step(1'b0, 1'b0);
    check_eq("release_lvl", 32'(level), 32'd12);

    // Read side tracks the write pointer; 40 pushes across the wrap.
    for (int i = 0; i < 40; i++) begin
      rd_cnt    = m_wcnt;
      prev_gray = ptr_gray;
      step(1'b1, 1'b0);
      check_eq("gray_1bit", 32'($countones(ptr_gray ^ prev_gray)), 32'(last_push));
    end

    // Randomised traffic with reads never passing accepted writes.
    for (int i = 0; i < 600; i++) begin
      if (rd_cnt < m_wcnt && $urandom_range(0, 2) != 0) rd_cnt += 1;
      step(1'($urandom_range(0, 99) < 60), 1'b0);
    end

    // Mid-operation reset after seven writes.
    rd_cnt = 0;
    step(1'b0, 1'b1);
    for (int i = 0; i < 7; i++) step(1'b1, 1'b0);
    step(1'b1, 1'b1);
    check_eq("midrst_ptr", 32'(ptr_bin), 32'd0);
    for (int i = 0; i < 5; i++) step(1'b1, 1'b0);

    // Random bursts biased toward full to exercise overflow and threshold edges.
    for (int i = 0; i < 300; i++) begin
      if (rd_cnt < m_wcnt && $urandom_range(0, 3) == 0) rd_cnt += $urandom_range(1, 3);
      if (rd_cnt > m_wcnt) rd_cnt = m_wcnt;
      step(1'($urandom_range(0, 99) < 85), 1'b0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
